dual_edge_logic_pipe: RTL

Parametrised successor to the team's dual-edge logic registers. Operands are captured on the falling edge of one clock into a half-cycle stage, then carried through a configurable number of rising-edge stages with valid/ready flow control. Output transfers are counted. The block sits between a valid/ready producer and consumer in the same clock domain and uses both edges of `clk`.

---
 rtl/dual_edge_logic_pipe.sv | 119 +++++++++++
 1 files changed

// File: rtl/dual_edge_logic_pipe.sv
// Logic pipe using both clock edges: a falling-edge operand stage (H) feeding
// DEPTH rising-edge stages with valid/ready flow control and a transfer counter.
module dual_edge_logic_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             mask_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic [CNT_W-1:0] xfer_cnt
);

    // Handshake: a transfer happens on an edge where valid and ready are both 1;
    // valid never depends on ready, and a held item keeps its data stable.

    // H occupancy is a token pair so each flag is written from a single edge:
    // the falling edge flips h_put on capture, the rising edge flips h_take on drain.
    logic [WIDTH-1:0] t_q, b_h_q;
    logic             m_h_q;
    logic             h_put_q;
    logic             h_take_q, h_take_d;
    logic             h_valid;
    logic [WIDTH-1:0] op_res;

    logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
    logic [DEPTH-1:0]            v_q, v_d;
    logic [DEPTH-1:0]            free;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [WIDTH-1:0]            s1_in;
    logic                        f_run;

    assign h_valid  = h_put_q ^ h_take_q;
    assign in_ready = !rst && !h_valid;

    always_comb begin
        op_res = '0;
        case (op)
            2'b00:   op_res = a & b;
            2'b01:   op_res = a | b;
            2'b10:   op_res = a ^ b;
            default: op_res = ~(a & b);
        endcase
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            t_q     <= '0;
            b_h_q   <= '0;
            m_h_q   <= 1'b0;
            h_put_q <= 1'b0;
        end else if (in_valid && in_ready) begin
            t_q     <= op_res;
            b_h_q   <= b;
            m_h_q   <= mask_en;
            h_put_q <= ~h_put_q;
        end
    end

    // The mask sits on the half-period path from H into the first rising stage.
    assign s1_in = m_h_q ? (t_q & b_h_q) : t_q;

    always_comb begin
        free  = '0;
        f_run = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            f_run   = !v_q[k] || f_run;
            free[k] = f_run;
        end
    end

    always_comb begin
        v_d      = v_q;
        data_d   = data_q;
        h_take_d = h_take_q;
        cnt_d    = cnt_q;
        if (free[0]) begin
            v_d[0] = h_valid;
            if (h_valid) begin
                data_d[0] = s1_in;
                h_take_d  = ~h_take_q;
            end
        end
        for (int k = 1; k < DEPTH; k++) begin
            if (free[k]) begin
                v_d[k] = v_q[k-1];
                if (v_q[k-1]) data_d[k] = data_q[k-1];
            end
        end
        if (v_q[DEPTH-1] && out_ready) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q      <= '0;
            data_q   <= '0;
            h_take_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            v_q      <= v_d;
            data_q   <= data_d;
            h_take_q <= h_take_d;
            cnt_q    <= cnt_d;
        end
    end

    assign f         = data_q[DEPTH-1];
    assign out_valid = v_q[DEPTH-1];
    assign xfer_cnt  = cnt_q;

endmodule
